// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its downstream consumers.
//   - ALU_OPW / XLEN : default opcode and datapath widths
//   - alu_op_e       : aluOp encodings (10..15 are unassigned and execute as ADD)
//   - SET_*          : setType encodings read by the set-on-compare logic
//   - alu_entry_t    : one buffered instruction record {result, C, Z, setType}
package alu_pkg;

    localparam int ALU_OPW = 4;
    localparam int XLEN    = 32;

    typedef enum logic [ALU_OPW-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_PASSB = 4'd9
    } alu_op_e;

    localparam logic [1:0] SET_SLT  = 2'b00;
    localparam logic [1:0] SET_SLE  = 2'b10;
    localparam logic [1:0] SET_NONE = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            c;
        logic            z;
        logic [1:0]      set_type;
    } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: opA/opB/aluOp -> result, carry, zero.
//   opA, opB : WIDTH-bit operands (opB[4:0] is the shift amount for shifts)
//   aluOp    : OPW-bit operation select
//   result   : WIDTH-bit result, modulo 2^WIDTH
//   c        : carry-out for ADD, no-borrow for SUB, 0 otherwise
//   z        : result == 0
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int OPW   = ALU_OPW
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [OPW-1:0]   aluOp,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             z
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [4:0]     shamt;

    // SUB as opA + ~opB + 1 so the carry-out reads as opA >= opB unsigned;
    // downstream SLT/SLE depend on exactly this sense of C.
    assign sum   = {1'b0, opA} + {1'b0, opB};
    assign diff  = {1'b0, opA} + {1'b0, ~opB} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt = opB[4:0];

    always_comb begin
        result = sum[WIDTH-1:0];
        c      = 1'b0;
        case (aluOp)
            ALU_SUB: begin
                result = diff[WIDTH-1:0];
                c      = diff[WIDTH];
            end
            ALU_AND:   result = opA & opB;
            ALU_OR:    result = opA | opB;
            ALU_XOR:   result = opA ^ opB;
            ALU_NOR:   result = ~(opA | opB);
            ALU_SLL:   result = opA << shamt;
            ALU_SRL:   result = opA >> shamt;
            ALU_SRA:   result = $signed(opA) >>> shamt;
            ALU_PASSB: result = opB;
            // ADD and the unassigned codes
            default: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
            end
        endcase
    end

    assign z = (result == '0);

endmodule

// File: rtl/alu_flag_stage.sv
// Execute stage: ALU result + C/Z flags registered into a 2-entry skid buffer.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : upstream handshake; in_ready is registered and
//                           depends only on occupancy (low only when FULL)
//   opA, opB, aluOp       : instruction operands and operation
//   setTypeIn             : set-compare type carried with the instruction
//   flush                 : synchronous drop of all buffered entries
//   out_valid / out_ready : downstream handshake on the head entry
//   aluResult, C, Z,
//   setTypeOut            : head entry fields, held while stalled
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [OPW-1:0]   aluOp,
    input  logic [1:0]       setTypeIn,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluResult,
    output logic             C,
    output logic             Z,
    output logic [1:0]       setTypeOut
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // Local record so the buffer follows WIDTH; same layout as alu_entry_t.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             c;
        logic             z;
        logic [1:0]       set_type;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{result: '0, c: 1'b0, z: 1'b0, set_type: SET_NONE};

    buf_state_e       state_q;
    entry_t           head_q;
    entry_t           tail_q;
    entry_t           new_entry;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] core_result;
    logic             core_c;
    logic             core_z;

    alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_core (
        .opA    (opA),
        .opB    (opB),
        .aluOp  (aluOp),
        .result (core_result),
        .c      (core_c),
        .z      (core_z)
    );

    assign new_entry = '{result: core_result, c: core_c, z: core_z, set_type: setTypeIn};
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid_q & out_ready;

    // Occupancy FSM. out_valid_q/in_ready_q are kept as registered copies of
    // (state != EMPTY)/(state != FULL) so neither output has a comb path.
    // The head register is always the oldest entry; tail is only live in FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_q      <= RESET_ENTRY;
            tail_q      <= RESET_ENTRY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            // Same-cycle accept/consume are discarded; data regs hold.
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q      <= new_entry;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    case ({accept, consume})
                        2'b10: begin
                            tail_q     <= new_entry;
                            state_q    <= FULL;
                            in_ready_q <= 1'b0;
                        end
                        2'b01: begin
                            state_q     <= EMPTY;
                            out_valid_q <= 1'b0;
                        end
                        2'b11: head_q <= new_entry;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (consume) begin
                        head_q     <= tail_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign aluResult  = head_q.result;
    assign C          = head_q.c;
    assign Z          = head_q.z;
    assign setTypeOut = head_q.set_type;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Bench for alu_flag_stage: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu_flag_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [3:0]  aluOp;
    logic [1:0]  setTypeIn;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluResult;
    logic        C;
    logic        Z;
    logic [1:0]  setTypeOut;

    int total = 0;
    int bad   = 0;

    alu_flag_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opA        (opA),
        .opB        (opB),
        .aluOp      (aluOp),
        .setTypeIn  (setTypeIn),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .aluResult  (aluResult),
        .C          (C),
        .Z          (Z),
        .setTypeOut (setTypeOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic [1:0]  st;
    } exp_t;

    exp_t q[$];

    // What the instruction must produce, straight from the op table.
    function automatic exp_t model_op(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [1:0] st);
        exp_t        e;
        logic [63:0] wide;
        e.c = 1'b0;
        case (op)
            4'd1: begin e.r = a - b; e.c = (a >= b); end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = ~(a | b);
            4'd6: e.r = a << b[4:0];
            4'd7: e.r = a >> b[4:0];
            4'd8: e.r = $signed(a) >>> b[4:0];
            4'd9: e.r = b;
            default: begin
                wide = {32'b0, a} + {32'b0, b};
                e.r  = wide[31:0];
                e.c  = wide[32];
            end
        endcase
        e.z  = (e.r == 32'b0);
        e.st = st;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of depth 2, acceptance decided on pre-edge occupancy.
    always @(negedge rst_n) q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else begin
                automatic bit take = in_valid && (q.size() < 2);
                automatic bit pop  = (q.size() > 0) && out_ready;
                if (pop) void'(q.pop_front());
                if (take) q.push_back(model_op(aluOp, opA, opB, setTypeIn));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
            if (q.size() != 0) begin
                check("head_result", aluResult, q[0].r);
                check("head_c", {31'b0, C}, {31'b0, q[0].c});
                check("head_z", {31'b0, Z}, {31'b0, q[0].z});
                check("head_st", {30'b0, setTypeOut}, {30'b0, q[0].st});
            end
        end
    end

    task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] st);
        in_valid  = v;
        aluOp     = op;
        opA       = a;
        opB       = b;
        setTypeIn = st;
    endtask

    task automatic chk_head(input string name, input logic [31:0] r, input logic c,
                            input logic z, input logic [1:0] st);
        check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, "_res"}, aluResult, r);
        check({name, "_c"}, {31'b0, C}, {31'b0, c});
        check({name, "_z"}, {31'b0, Z}, {31'b0, z});
        check({name, "_st"}, {30'b0, setTypeOut}, {30'b0, st});
    endtask

    logic [31:0] vec_a [5] = '{32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h3};
    logic [31:0] vec_b [5] = '{32'h0, 32'h1, 32'h9ABC_DEF0, 32'h1F, 32'hFFFF_FFFF};

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00);
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_result", aluResult, 32'd0);
        check("rst_cz", {30'b0, C, Z}, 32'd0);
        check("rst_st", {30'b0, setTypeOut}, 32'd3);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // SUB 5-9 from empty: one cycle latency
        @(negedge clk); set_in(1'b1, 4'd1, 32'd5, 32'd9, 2'b00);
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00);
        chk_head("sub_neg", 32'hFFFF_FFFC, 1'b0, 1'b0, 2'b00);

        // SUB 7-7, then ADD wrap, back to back
        @(negedge clk); set_in(1'b1, 4'd1, 32'd7, 32'd7, 2'b10);
        @(negedge clk); set_in(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 2'b11);
        chk_head("sub_eq", 32'd0, 1'b1, 1'b1, 2'b10);
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00);
        chk_head("add_wrap", 32'd0, 1'b1, 1'b1, 2'b11);

        // Streaming in ONE: head refreshes every cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); set_in(1'b1, 4'd0, 32'(i * 3), 32'd1, 2'b00);
            if (i > 0) begin
                check("stream_res", aluResult, 32'((i - 1) * 3 + 1));
                check("stream_rdy", {31'b0, in_ready}, 32'd1);
            end
        end
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00);
        check("stream_last", aluResult, 32'd16);
        @(negedge clk);

        // Backpressure: fill, third offer refused, drain in order
        out_ready = 1'b0;
        set_in(1'b1, 4'd0, 32'd1, 32'd1, 2'b00);
        @(negedge clk); set_in(1'b1, 4'd0, 32'd2, 32'd2, 2'b00);
        @(negedge clk); set_in(1'b1, 4'd0, 32'd3, 32'd3, 2'b00);
        check("bp_full_rdy", {31'b0, in_ready}, 32'd0);
        check("bp_head1", aluResult, 32'd2);
        @(negedge clk);
        check("bp_hold_rdy", {31'b0, in_ready}, 32'd0);
        check("bp_hold_head", aluResult, 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_head2", aluResult, 32'd4);
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00);
        check("bp_head3", aluResult, 32'd6);
        @(negedge clk);
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush in ONE with a concurrent accept
        out_ready = 1'b0;
        set_in(1'b1, 4'd0, 32'd50, 32'd0, 2'b00);
        @(negedge clk); set_in(1'b1, 4'd0, 32'd60, 32'd0, 2'b00); flush = 1'b1;
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00); flush = 1'b0;
        check("fl1_valid", {31'b0, out_valid}, 32'd0);
        check("fl1_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        check("fl1_stay", {31'b0, out_valid}, 32'd0);

        // Flush while FULL with in_valid and out_ready up
        set_in(1'b1, 4'd0, 32'd10, 32'd0, 2'b00);
        @(negedge clk); set_in(1'b1, 4'd0, 32'd20, 32'd0, 2'b00);
        @(negedge clk);
        check("fl2_full", {31'b0, in_ready}, 32'd0);
        set_in(1'b1, 4'd0, 32'd99, 32'd0, 2'b00); flush = 1'b1; out_ready = 1'b1;
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00); flush = 1'b0;
        check("fl2_valid", {31'b0, out_valid}, 32'd0);
        check("fl2_rdy", {31'b0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);

        // Async reset mid-cycle while FULL
        out_ready = 1'b0;
        set_in(1'b1, 4'd0, 32'd5, 32'd5, 2'b00);
        @(negedge clk); set_in(1'b1, 4'd0, 32'd6, 32'd6, 2'b00);
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00);
        check("ar_full", {31'b0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'b0, out_valid}, 32'd0);
        check("ar_rdy", {31'b0, in_ready}, 32'd1);
        check("ar_result", aluResult, 32'd0);
        check("ar_st", {30'b0, setTypeOut}, 32'd3);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk); set_in(1'b1, 4'd8, 32'h8000_0000, 32'd4, 2'b00);
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00);
        chk_head("sra", 32'hF800_0000, 1'b0, 1'b0, 2'b00);

        // Every opcode against a few operand pairs, with intermittent stalls
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                set_in(1'b1, 4'(op), vec_a[k], vec_b[k], 2'(op + k));
                out_ready = ((op + k) % 3 != 0);
            end
        end
        @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 2'b00); out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
